// File: rtl/sound_pkg.sv
// Shared types and constants for the game sound player: FSM states,
// tune indices and the half-period table of both jingles.
package sound_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PLAY,
    GAP,
    DONE
  } snd_state_t;

  localparam int TUNE_LOSE = 0;
  localparam int TUNE_WIN  = 1;
  localparam int HP_W      = 17;

  // Half-periods in 50 MHz clocks; a zero entry is a rest (silent note).
  localparam logic [HP_W-1:0] NOTE_TABLE [2][4] = '{
    '{17'd63776, 17'd75843, 17'd95556, 17'd0},      // LOSE: G4 E4 C4 rest
    '{17'd47778, 17'd37922, 17'd31888, 17'd23889}   // WIN:  C5 E5 G5 C6
  };

  // Table lookup kept in one place so the top only deals with tune/note.
  function automatic logic [HP_W-1:0] note_hp(input logic tune, input logic [1:0] idx);
    if (tune)
      return NOTE_TABLE[TUNE_WIN][idx];
    else
      return NOTE_TABLE[TUNE_LOSE][idx];
  endfunction

endpackage

// File: rtl/tone_divider.sv
// Square-wave generator: toggles its phase every hp cycles while run is high.
// hp == 0 is treated as a rest (counter and phase frozen). clear returns
// the divider to phase 0 / count 0 so every note starts from the same point.
import sound_pkg::*;

module tone_divider #(
  parameter int W = HP_W
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic [W-1:0] hp,
  input  logic         run,
  input  logic         clear,
  output logic         square,
  output logic         toggle
);

  logic [W-1:0] cnt;
  logic         active;

  assign active = run && (hp != '0);
  assign toggle = active && (cnt == hp - W'(1));

  // Half-period counter and phase register; counter stops at hp-1 so it never wraps.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      cnt    <= '0;
      square <= 1'b0;
    end else if (clear) begin
      cnt    <= '0;
      square <= 1'b0;
    end else if (active) begin
      if (toggle) begin
        cnt    <= '0;
        square <= ~square;
      end else begin
        cnt <= cnt + W'(1);
      end
    end
  end

endmodule

// File: rtl/game_sound_player.sv
// Game sound player: on a rising edge of enable_sound with a valid tune index
// it plays a 4-note melody (note, then silent gap, per note) as a square wave.
// A new valid request at any time restarts from the first note.
//
//   state | meaning
//   IDLE  | waiting for a valid start edge
//   LOAD  | one cycle: fetch half-period of the current note
//   PLAY  | tone running for NOTE_LEN cycles
//   GAP   | silence for GAP_LEN cycles, then next note or DONE
//   DONE  | one cycle: done pulse
import sound_pkg::*;

module game_sound_player #(
  parameter int NOTE_LEN    = 12_500_000,
  parameter int GAP_LEN     = 1_250_000,
  parameter int PITCH_SHIFT = 0,
  parameter int DUR_W       = 24
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       enable_sound,
  input  logic [9:0] sound_freq,
  input  logic       mute,
  output logic       audio_out,
  output logic       busy,
  output logic       done,
  output logic [1:0] note_idx
);

  snd_state_t        state;
  snd_state_t        state_next;
  logic              en_d;
  logic              start;
  logic              start_valid;
  logic              tune;
  logic [HP_W-1:0]   hp;
  logic [DUR_W-1:0]  dur;
  logic              note_end;
  logic              gap_end;
  logic              tone_run;
  logic              tone_clear;
  logic              tone_square;
  logic              tone_toggle;
  logic              play_hold;

  assign start       = enable_sound & ~en_d;
  assign start_valid = start && (sound_freq <= 10'd1);
  assign note_end    = (state == PLAY) && (dur == DUR_W'(NOTE_LEN - 1));
  assign gap_end     = (state == GAP)  && (dur == DUR_W'(GAP_LEN - 1));
  assign tone_run    = (state == PLAY);
  assign tone_clear  = (state != PLAY);
  // Only drive the pin while staying in PLAY; LOAD/GAP/retrigger force silence.
  assign play_hold   = (state == PLAY) && (state_next == PLAY);
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

  tone_divider #(.W(HP_W)) u_tone (
    .clk    (clk),
    .resetN (resetN),
    .hp     (hp),
    .run    (tone_run),
    .clear  (tone_clear),
    .square (tone_square),
    .toggle (tone_toggle)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!resetN)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next-state logic; a valid start overrides everything, including DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = IDLE;
      LOAD:    state_next = PLAY;
      PLAY:    if (note_end) state_next = GAP;
      GAP:     if (gap_end)  state_next = (note_idx == 2'd3) ? DONE : LOAD;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (start_valid)
      state_next = LOAD;
  end

  // Request edge detector.
  always_ff @(posedge clk) begin
    if (!resetN)
      en_d <= 1'b0;
    else
      en_d <= enable_sound;
  end

  // Tune latch and note sequencing.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      tune     <= 1'b0;
      note_idx <= 2'd0;
    end else if (start_valid) begin
      tune     <= sound_freq[0];
      note_idx <= 2'd0;
    end else if (gap_end && (note_idx != 2'd3)) begin
      note_idx <= note_idx + 2'd1;
    end
  end

  // Half-period fetch for the note about to play.
  always_ff @(posedge clk) begin
    if (!resetN)
      hp <= '0;
    else if (state == LOAD)
      hp <= note_hp(tune, note_idx) >> PITCH_SHIFT;
  end

  // Shared note/gap duration counter, cleared on every phase change.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      dur <= '0;
    end else begin
      case (state)
        PLAY:    dur <= note_end ? '0 : dur + DUR_W'(1);
        GAP:     dur <= gap_end  ? '0 : dur + DUR_W'(1);
        default: dur <= '0;
      endcase
    end
  end

  // Output register; mute gates the pin only, the divider phase keeps running.
  always_ff @(posedge clk) begin
    if (!resetN)
      audio_out <= 1'b0;
    else
      audio_out <= ~mute & play_hold & (tone_square ^ tone_toggle);
  end

endmodule

// File: tb/tb_game_sound_player.sv
// Self-checking bench for game_sound_player with short simulation timing.
// Expected audio edges and done pulses are pushed to queues when a tune is
// started and popped when the DUT produces them.
module tb_game_sound_player;

  localparam int NOTE = 400;
  localparam int GAPL = 40;
  localparam int PER  = 1 + NOTE + GAPL;
  localparam int TUNE_CYC = 4 * PER + 1;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       enable_sound = 1'b0;
  logic [9:0] sound_freq = 10'd0;
  logic       mute = 1'b0;
  logic       audio_out;
  logic       busy;
  logic       done;
  logic [1:0] note_idx;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int exp_edges[$];
  int exp_done[$];
  logic prev_audio = 1'b0;
  int hp_lose[4] = '{62, 74, 93, 0};
  int hp_win[4]  = '{46, 37, 31, 23};

  game_sound_player #(
    .NOTE_LEN(NOTE), .GAP_LEN(GAPL), .PITCH_SHIFT(10), .DUR_W(24)
  ) dut (
    .clk(clk), .resetN(resetN), .enable_sound(enable_sound), .sound_freq(sound_freq),
    .mute(mute), .audio_out(audio_out), .busy(busy), .done(done), .note_idx(note_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected pin level k cycles after the start edge (k=1 is the LOAD cycle).
  function automatic bit exp_level(int tune, int k, bit muted);
    int j, o, p, hp;
    if (muted || k < 1 || k > 4 * PER) return 1'b0;
    j = (k - 1) / PER;
    o = (k - 1) % PER;
    if (o < 1 || o > NOTE) return 1'b0;
    hp = tune ? hp_win[j] : hp_lose[j];
    if (hp == 0) return 1'b0;
    p = o - 1;
    return ((p / hp) % 2) == 1;
  endfunction

  task automatic push_tune(input int c, input int tune, input bit muted, input bit prev);
    bit lv, pv;
    pv = prev;
    for (int k = 1; k <= TUNE_CYC + 1; k++) begin
      lv = exp_level(tune, k, muted);
      if (lv != pv) exp_edges.push_back(c + k);
      pv = lv;
    end
    exp_done.push_back(c + TUNE_CYC);
  endtask

  task automatic run_and_check(input int n, output int highs);
    int e;
    highs = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (audio_out === 1'b1) highs++;
      if (audio_out !== prev_audio) begin
        n_checks++;
        if (exp_edges.size() == 0) begin
          n_errors++;
          $display("FAIL audio_edge: change to %0b at cycle %0d, none expected", audio_out, cyc);
        end else begin
          e = exp_edges.pop_front();
          if (e != cyc) begin
            n_errors++;
            $display("FAIL audio_edge: change to %0b at cycle %0d, expected at %0d", audio_out, cyc, e);
          end
        end
        prev_audio = audio_out;
      end
      if (done !== 1'b0) begin
        n_checks++;
        if (exp_done.size() == 0) begin
          n_errors++;
          $display("FAIL done_pulse: done=%b at cycle %0d, none expected", done, cyc);
        end else begin
          e = exp_done.pop_front();
          if (e != cyc) begin
            n_errors++;
            $display("FAIL done_pulse: done at cycle %0d, expected at %0d", cyc, e);
          end
        end
      end
    end
  endtask

  task automatic check_drained(input string name);
    n_checks++;
    if (exp_edges.size() != 0) begin
      n_errors++;
      $display("FAIL %s_edges_left: %0d audio edges never seen, expected 0", name, exp_edges.size());
    end
    n_checks++;
    if (exp_done.size() != 0) begin
      n_errors++;
      $display("FAIL %s_done_left: %0d done pulses never seen, expected 0", name, exp_done.size());
    end
  endtask

  task automatic test_reset;
    resetN = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({audio_out, busy, done, note_idx} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_state: audio=%b busy=%b done=%b idx=%0d, expected all 0",
               audio_out, busy, done, note_idx);
    end
    resetN = 1'b1;
    @(negedge clk);
    prev_audio = audio_out;
  endtask

  task automatic test_reset_mid_play;
    int c, h;
    sound_freq = 10'd1; enable_sound = 1'b1; c = cyc;
    push_tune(c, 1, 1'b0, prev_audio);
    run_and_check(10, h);
    enable_sound = 1'b0;
    run_and_check(50, h);
    n_checks++;
    if (audio_out !== 1'b1 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL pre_reset_play: audio=%b busy=%b, expected 1 1", audio_out, busy);
    end
    resetN = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({audio_out, busy, done, note_idx} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_mid_play: audio=%b busy=%b done=%b idx=%0d, expected all 0",
               audio_out, busy, done, note_idx);
    end
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    exp_edges.delete(); exp_done.delete();
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL post_reset_idle: busy=%b, expected 0", busy);
    end
    prev_audio = audio_out;
  endtask

  task automatic test_win;
    int c, h;
    sound_freq = 10'd1; enable_sound = 1'b1; c = cyc;
    push_tune(c, 1, 1'b0, prev_audio);
    run_and_check(1, h);
    n_checks++;
    if (busy !== 1'b1 || note_idx !== 2'd0) begin
      n_errors++;
      $display("FAIL win_latency: busy=%b idx=%0d, expected 1 0", busy, note_idx);
    end
    run_and_check(499, h);
    n_checks++;
    if (note_idx !== 2'd1) begin
      n_errors++;
      $display("FAIL win_note1: idx=%0d, expected 1", note_idx);
    end
    run_and_check(TUNE_CYC - 500, h);
    run_and_check(35, h);
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL win_single_start: busy=%b with enable held, expected 0", busy);
    end
    enable_sound = 1'b0;
    run_and_check(5, h);
    check_drained("win");
  endtask

  task automatic test_lose;
    int c, h;
    sound_freq = 10'd0; enable_sound = 1'b1; c = cyc;
    push_tune(c, 0, 1'b0, prev_audio);
    run_and_check(1, h);
    enable_sound = 1'b0;
    run_and_check(3 * PER, h);
    n_checks++;
    if (note_idx !== 2'd3) begin
      n_errors++;
      $display("FAIL lose_note3: idx=%0d, expected 3", note_idx);
    end
    run_and_check(NOTE, h);
    n_checks++;
    if (h != 0) begin
      n_errors++;
      $display("FAIL lose_rest: audio high %0d cycles during rest, expected 0", h);
    end
    run_and_check(100, h);
    check_drained("lose");
  endtask

  task automatic test_invalid;
    int bad;
    bad = 0;
    sound_freq = 10'd5; enable_sound = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (i == 20) enable_sound = 1'b0;
      if (busy !== 1'b0) bad++;
      if (audio_out !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL invalid_ignored: %0d bad samples of busy/audio, expected 0", bad);
    end
    n_checks++;
    if (note_idx !== 2'd3) begin
      n_errors++;
      $display("FAIL invalid_no_state: idx=%0d, expected 3 (unchanged)", note_idx);
    end
    prev_audio = audio_out;
  endtask

  task automatic test_retrigger;
    int c1, c2, h;
    bit lv;
    sound_freq = 10'd1; enable_sound = 1'b1; c1 = cyc;
    push_tune(c1, 1, 1'b0, prev_audio);
    run_and_check(10, h);
    enable_sound = 1'b0;
    run_and_check(590, h);
    sound_freq = 10'd7; enable_sound = 1'b1;
    run_and_check(5, h);
    enable_sound = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || note_idx !== 2'd1) begin
      n_errors++;
      $display("FAIL invalid_while_busy: busy=%b idx=%0d, expected 1 1", busy, note_idx);
    end
    run_and_check(295, h);
    n_checks++;
    if (note_idx !== 2'd2) begin
      n_errors++;
      $display("FAIL retrig_pre: idx=%0d, expected 2", note_idx);
    end
    c2 = cyc;
    while (exp_edges.size() > 0 && exp_edges[$] > c2) void'(exp_edges.pop_back());
    while (exp_done.size() > 0 && exp_done[$] > c2) void'(exp_done.pop_back());
    lv = exp_level(1, c2 - c1, 1'b0);
    push_tune(c2, 0, 1'b0, lv);
    sound_freq = 10'd0; enable_sound = 1'b1;
    run_and_check(1, h);
    n_checks++;
    if (busy !== 1'b1 || note_idx !== 2'd0) begin
      n_errors++;
      $display("FAIL retrig_load: busy=%b idx=%0d, expected 1 0", busy, note_idx);
    end
    enable_sound = 1'b0;
    run_and_check(TUNE_CYC + 30, h);
    check_drained("retrig");
  endtask

  task automatic test_back_to_back;
    int c, c2, h;
    sound_freq = 10'd1; enable_sound = 1'b1; c = cyc;
    push_tune(c, 1, 1'b0, prev_audio);
    run_and_check(1, h);
    enable_sound = 1'b0;
    run_and_check(TUNE_CYC - 1, h);
    c2 = cyc;
    push_tune(c2, 0, 1'b0, 1'b0);
    sound_freq = 10'd0; enable_sound = 1'b1;
    run_and_check(1, h);
    n_checks++;
    if (busy !== 1'b1 || note_idx !== 2'd0) begin
      n_errors++;
      $display("FAIL start_in_done: busy=%b idx=%0d, expected 1 0", busy, note_idx);
    end
    enable_sound = 1'b0;
    run_and_check(TUNE_CYC + 30, h);
    check_drained("b2b");
  endtask

  task automatic test_mute;
    int c, h, tot;
    mute = 1'b1; sound_freq = 10'd1; enable_sound = 1'b1; c = cyc;
    push_tune(c, 1, 1'b1, prev_audio);
    run_and_check(1, h);
    tot = h;
    enable_sound = 1'b0;
    run_and_check(TUNE_CYC + 30, h);
    tot += h;
    n_checks++;
    if (tot != 0) begin
      n_errors++;
      $display("FAIL mute_silent: audio high %0d cycles while muted, expected 0", tot);
    end
    mute = 1'b0;
    check_drained("mute");
  endtask

  initial begin
    test_reset();
    test_reset_mid_play();
    test_win();
    test_lose();
    test_invalid();
    test_retrigger();
    test_back_to_back();
    test_mute();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
